alu_issue_arb: RTL
==================

ALU_ISSUE_ARB -- requirements
Module: alu_issue_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters sharing the ALU (legal range 2..4).
REQ-002 SHALL have parameter IDX_W, default 1, width of requester index; equals clog2(N_REQ).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  decoupled.in  array[N_REQ], each carrying decoded_instr  decoded ALU-class instructions from requester i.
REQ-006 SHALL have port issue  decoupled.out  decoded_instr  instruction presented to the shared ALU.
REQ-007 SHALL have port issue_src  output  IDX_W  index of the requester that owns the instruction on issue.
REQ-008 SHALL have port flush  input  1  pipeline flush; discards the held instruction.
REQ-009 SHALL have port busy  output  1  high while the holding register is valid.

Function
REQ-010 SHALL contain one holding register: hold_valid, hold_data, hold_src.
REQ-011 issue.valid SHALL equal hold_valid; issue.data SHALL equal hold_data; issue_src SHALL equal hold_src; busy SHALL equal hold_valid.
REQ-012 slot_free SHALL be (!hold_valid || issue.ready) && !flush.
REQ-013 Grant: round-robin over valid requests, scanning from pointer rr_ptr upward with wrap-around at N_REQ-1 -> 0; at most one grant per cycle.
REQ-014 req[i].ready SHALL be 1 only when i is granted and slot_free; ready SHALL NOT depend on req[i].valid of any other requester beyond the grant computation.
REQ-015 On accept (req[g].valid && req[g].ready) the holding register SHALL load data and src=g at the next edge; latency input accept -> issue.valid = 1 cycle.
REQ-016 On accept rr_ptr SHALL become (g+1) mod N_REQ; with no accept rr_ptr SHALL hold.
REQ-017 Simultaneous issue handshake and accept SHALL replace the held entry without a bubble; sustained throughput 1 instr/cycle.
REQ-018 Issue handshake with no accept SHALL clear hold_valid at the next edge.
REQ-019 While hold_valid && !issue.ready, hold_data and hold_src SHALL remain stable and all req[i].ready SHALL be 0.
REQ-020 flush SHALL clear hold_valid at the next edge, block all accepts that cycle, and leave rr_ptr unchanged; flush overrides a coincident issue handshake (ALU result of that cycle is dropped downstream).
REQ-021 With no valid requests, all ready SHALL be 0 and state other than hold_valid clearing per REQ-018 SHALL hold.
REQ-022 No requester with valid held high SHALL wait more than N_REQ accepts for a grant.

Reset
REQ-023 On rst at a rising edge: hold_valid=0, hold_src=0, rst_ptr=0; hold_data SHALL be don't-care.
REQ-024 Reset SHALL override flush and any in-flight handshake; outputs after reset: issue.valid=0, busy=0, issue_src=0, all req[i].ready=0 during the reset cycle.

Structure
REQ-025 decoded_instr and the decoupled interface SHALL come from the shared types package; N_REQ maximum SHALL be a package constant.
REQ-026 The round-robin picker SHALL be a sub-module rr_picker (inputs valid vector, pointer; outputs one-hot grant, grant index, any).
REQ-027 Module SHALL be free of latches and use only clk/rst as clocking/reset.

Verification
REQ-028 Reset then req[0].valid=1 data=ADD x1,x2,x3 with issue.ready=1 -> req[0].ready=1 cycle 0, issue.valid=1 with src=0 cycle 1.
REQ-029 Both requesters valid continuously, issue.ready=1 -> grants alternate 0,1,0,1; issue_src sequence 0,1,0,1 from cycle 1.
REQ-030 hold_valid=1, issue.ready=0 for 3 cycles -> issue.data stable, all ready=0; on ready=1 new entry loads same edge, no bubble.
REQ-031 flush pulse while hold_valid=1 and req[1].valid=1 -> next cycle issue.valid=0, req[1] not accepted in flush cycle, rr_ptr unchanged.
REQ-032 rst asserted while hold_valid=1 and req[0] handshaking -> next cycle issue.valid=0, rr_ptr=0, no accept recorded.
REQ-033 N_REQ=3, requesters 0 and 2 valid, rr_ptr=1 -> requester 2 granted first, then 0.

Source files
------------

// File: rtl/alu_issue_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_arb_pkg
//  Description : Shared types for the ALU issue arbiter: decoded ALU-class
//                instruction format, requester-count limit and the
//                round-robin pointer advance helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_issue_arb_pkg;

    // Upper bound on the number of requesters that may share one ALU.
    localparam int N_REQ_MAX = 4;

    // ALU operation selector carried by a decoded instruction.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_e;

    // Decoded ALU-class instruction as handed from a requester to the ALU.
    typedef struct packed {
        alu_op_e     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
    } decoded_instr_t;

    // Round-robin pointer advance: the slot after idx, wrapping at n-1 -> 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : alu_issue_arb_pkg
`default_nettype wire

// File: rtl/alu_issue_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_arb_if
//  Description : Decoupled valid/ready/data bundle of N lanes carrying
//                decoded ALU instructions. N lanes for the requester side,
//                a single lane for the issue side.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_issue_arb_if #(
    parameter int N = 1
);
    import alu_issue_arb_pkg::*;

    logic           [N-1:0] valid;
    logic           [N-1:0] ready;
    decoded_instr_t [N-1:0] data;

    // Producer side drives valid/data, consumer side drives ready.
    modport master (output valid, output data, input ready);
    modport slave  (input  valid, input  data, output ready);

endinterface : alu_issue_arb_if
`default_nettype wire

// File: rtl/alu_issue_arb_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin picker. Scans the valid vector
//                starting at ptr and moving upward with wrap-around, and
//                returns the first valid lane as one-hot and as an index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    // First valid lane at or after ptr in circular order wins; ptr is always < N.
    always_comb begin : p_pick
        int cand;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/alu_issue_arb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_arb
//  Description : Round-robin arbiter feeding one shared ALU from N_REQ
//                requesters through a single holding register. Sustains one
//                instruction per cycle, holds under backpressure, and drops
//                the held entry on flush.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_arb
    import alu_issue_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_arb_if.slave   req,
    alu_issue_arb_if.master  issue,
    output logic [IDX_W-1:0] issue_src,
    input  logic             flush,
    output logic             busy
);

    // Holding register and round-robin pointer.
    logic             hold_valid_q, hold_valid_d;
    decoded_instr_t   hold_data_q,  hold_data_d;
    logic [IDX_W-1:0] hold_src_q,   hold_src_d;
    logic [IDX_W-1:0] rr_ptr_q,     rr_ptr_d;

    // Arbitration results.
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             slot_free;
    logic             accept_en;
    logic             accept;

    rr_picker #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .valid     (req.valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Slot is free when the held entry is empty or leaving; flush and reset block loading.
    always_comb begin : p_handshake
        slot_free = (!hold_valid_q || issue.ready[0]) && !flush;
        accept_en = slot_free && !rst;
        accept    = accept_en && grant_any;
        req.ready = accept_en ? grant : '0;
    end

    // Next state: accept refills (bubble-free), otherwise flush or issue drains.
    always_comb begin : p_next
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_src_d   = hold_src_q;
        rr_ptr_d     = rr_ptr_q;
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = req.data[grant_idx];
            hold_src_d   = grant_idx;
            rr_ptr_d     = IDX_W'(rr_next(int'(grant_idx), N_REQ));
        end else if (flush || issue.ready[0]) begin
            hold_valid_d = 1'b0;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin : p_ctrl_q
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_src_q   <= '0;
            rr_ptr_q     <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_src_q   <= hold_src_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Payload register; contents are only meaningful while hold_valid_q is set.
    always_ff @(posedge clk) begin : p_data_q
        hold_data_q <= hold_data_d;
    end

    assign issue.valid[0] = hold_valid_q;
    assign issue.data[0]  = hold_data_q;
    assign issue_src      = hold_src_q;
    assign busy           = hold_valid_q;

endmodule : alu_issue_arb
`default_nettype wire
